// File: rtl/keypad_encoder_4_2.sv
// 4-to-2 priority keypad encoder with 2-flop input sync, debounce and one-shot valid/ack handshake.
// Optional multi-line flag is built only when MULTI_DETECT_EN is defined.
module keypad_encoder_4_2 #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] z,
  input  logic       ack,
  output logic [1:0] a,
  output logic       valid,
  output logic       multi
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  sync1_reg, zs_reg;
  logic [3:0]  p_reg, p_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [1:0]  a_reg, a_next;
  logic        valid_reg, valid_next;
  logic        multi_reg, multi_next;
  logic        db_done;
  logic        ack_taken;

  function automatic logic [1:0] enc(input logic [3:0] v);
    if (v[3])      enc = 2'b11;
    else if (v[2]) enc = 2'b10;
    else if (v[1]) enc = 2'b01;
    else           enc = 2'b00;
  endfunction

`ifdef MULTI_DETECT_EN
  function automatic logic more_than_one(input logic [3:0] v);
    logic [2:0] sum;
    sum = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    more_than_one = (sum > 3'd1);
  endfunction
`endif

  // State register: synchronizer, FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      zs_reg    <= '0;
      state_reg <= IDLE;
      p_reg     <= '0;
      cnt_reg   <= '0;
      a_reg     <= '0;
      valid_reg <= 1'b0;
      multi_reg <= 1'b0;
    end else begin
      sync1_reg <= z;
      zs_reg    <= sync1_reg;
      state_reg <= state_next;
      p_reg     <= p_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      valid_reg <= valid_next;
      multi_reg <= multi_next;
    end
  end

  assign ack_taken = ack && valid_reg;

  // Next-state logic; the counter is shared by DEBOUNCE and RELEASE
  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    cnt_next   = cnt_reg;
    db_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en && (zs_reg != 4'd0)) begin
          p_next     = zs_reg;
          cnt_next   = '0;
          state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!en || (zs_reg == 4'd0)) begin
          state_next = IDLE;
        end else if (zs_reg != p_reg) begin
          p_next   = zs_reg;
          cnt_next = '0;
        end else if (cnt_reg == DB_LAST) begin
          db_done    = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      HOLD: begin
        if (ack_taken) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (zs_reg != 4'd0) begin
          cnt_next = '0;
        end else if (cnt_reg == DB_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: a/multi only change at debounce exit, so they hold through HOLD and after
  always_comb begin
    a_next     = a_reg;
    valid_next = valid_reg;
    multi_next = multi_reg;
    if (db_done) begin
      a_next     = enc(p_reg);
      valid_next = 1'b1;
`ifdef MULTI_DETECT_EN
      multi_next = more_than_one(p_reg);
`else
      multi_next = 1'b0;
`endif
    end else if ((state_reg == HOLD) && ack_taken) begin
      valid_next = 1'b0;
    end
  end

  assign a     = a_reg;
  assign valid = valid_reg;
  assign multi = multi_reg;

endmodule

// File: tb/tb_keypad_encoder_4_2.sv
// Directed self-checking bench for keypad_encoder_4_2 at DB_CYCLES=4 (valid latency 7 edges).
// Multi-line expectations follow MULTI_DETECT_EN.
module tb_keypad_encoder_4_2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] z;
  logic       ack;
  logic [1:0] a;
  logic       valid;
  logic       multi;

  int checks = 0;
  int errors = 0;

`ifdef MULTI_DETECT_EN
  localparam logic MULTI_ON = 1'b1;
`else
  localparam logic MULTI_ON = 1'b0;
`endif

  keypad_encoder_4_2 #(.DB_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .z     (z),
    .ack   (ack),
    .a     (a),
    .valid (valid),
    .multi (multi)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_release();
    ack = 1'b0;
    z   = 4'b0000;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    z   = 4'b1111;
    en  = 1'b1;
    ack = 1'b0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (a !== 2'b00 || valid !== 1'b0 || multi !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: a=%b valid=%b multi=%b, want a=00 valid=0 multi=0", a, valid, multi);
    end
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i < 7) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL reset_early_valid: edge %0d valid=%b, want 0", i, valid);
        end
      end
    end
    checks++;
    if (valid !== 1'b1 || a !== 2'b11 || multi !== MULTI_ON) begin
      errors++;
      $display("FAIL reset_latency: valid=%b a=%b multi=%b, want valid=1 a=11 multi=%b", valid, a, multi, MULTI_ON);
    end
    $display("reset: z=1111 held through reset, a=%b valid=%b after 7 edges", a, valid);
    ack_pulse();
    settle_release();
  endtask

  task automatic test_press();
    int rises;
    z = 4'b0100;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i < 7) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL press_early_valid: edge %0d valid=%b, want 0", i, valid);
        end
      end
    end
    checks++;
    if (valid !== 1'b1 || a !== 2'b10) begin
      errors++;
      $display("FAIL press_latency: valid=%b a=%b, want valid=1 a=10", valid, a);
    end
    step();
    checks++;
    if (valid !== 1'b1 || a !== 2'b10) begin
      errors++;
      $display("FAIL press_hold: valid=%b a=%b, want valid=1 a=10", valid, a);
    end
    ack_pulse();
    checks++;
    if (valid !== 1'b0 || a !== 2'b10) begin
      errors++;
      $display("FAIL press_ack: valid=%b a=%b, want valid=0 a=10 retained", valid, a);
    end
    rises = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (valid === 1'b1) rises++;
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL press_no_repeat: %0d cycles with valid while held, want 0", rises);
    end
    $display("press: z=0100 -> a=%b, acked, held 50 cycles", a);
    settle_release();
  endtask

  task automatic test_bounce();
    int rises;
    logic prev;
    rises = 0;
    prev  = valid;
    for (int i = 0; i < 20; i++) begin
      z = ((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
      step();
      if (valid === 1'b1 && prev !== 1'b1) rises++;
      prev = valid;
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL bounce_during_toggle: %0d valid rises, want 0", rises);
    end
    z = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      step();
      if (valid === 1'b1 && prev !== 1'b1) rises++;
      prev = valid;
    end
    checks++;
    if (rises != 1 || valid !== 1'b1 || a !== 2'b10) begin
      errors++;
      $display("FAIL bounce_single: rises=%0d valid=%b a=%b, want rises=1 valid=1 a=10", rises, valid, a);
    end
    $display("bounce: toggled 20 cycles then stable, rises=%0d a=%b", rises, a);
    ack_pulse();
    settle_release();
  endtask

  task automatic test_multi();
    logic [3:0] pat  [3] = '{4'b1011, 4'b0011, 4'b0001};
    logic [1:0] exp_a[3] = '{2'b11, 2'b01, 2'b00};
    logic       exp_m[3] = '{MULTI_ON, MULTI_ON, 1'b0};
    for (int k = 0; k < 3; k++) begin
      z = pat[k];
      for (int i = 0; i < 7; i++) step();
      checks++;
      if (valid !== 1'b1 || a !== exp_a[k] || multi !== exp_m[k]) begin
        errors++;
        $display("FAIL multi_%b: valid=%b a=%b multi=%b, want valid=1 a=%b multi=%b",
                 pat[k], valid, a, multi, exp_a[k], exp_m[k]);
      end
      $display("encode: z=%b -> a=%b multi=%b", pat[k], a, multi);
      ack_pulse();
      settle_release();
    end
  endtask

  task automatic test_change_during_debounce();
    z = 4'b0001;
    for (int i = 0; i < 4; i++) step();
    z = 4'b0010;
    for (int i = 5; i <= 11; i++) begin
      step();
      if (i < 11) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL change_early_valid: edge %0d valid=%b, want 0", i, valid);
        end
      end
    end
    checks++;
    if (valid !== 1'b1 || a !== 2'b01) begin
      errors++;
      $display("FAIL change_restart: valid=%b a=%b, want valid=1 a=01", valid, a);
    end
    $display("change: 0001 -> 0010 mid-debounce, a=%b", a);
    ack_pulse();
    settle_release();
  endtask

  task automatic test_enable();
    int seen;
    en = 1'b0;
    z  = 4'b0010;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL en_low_ignored: valid high %0d cycles, want 0", seen);
    end
    settle_release();
    en = 1'b1;
    z  = 4'b0010;
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL en_drop_debounce: valid high %0d cycles, want 0", seen);
    end
    settle_release();
    en = 1'b1;
    z  = 4'b0010;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (valid !== 1'b1 || a !== 2'b01) begin
      errors++;
      $display("FAIL en_press: valid=%b a=%b, want valid=1 a=01", valid, a);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (valid !== 1'b1 || a !== 2'b01) begin
      errors++;
      $display("FAIL en_drop_hold: valid=%b a=%b, want valid=1 a=01", valid, a);
    end
    ack_pulse();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL en_low_ack: valid=%b, want 0", valid);
    end
    $display("enable: en low ignored, debounce abort, hold survives en drop");
    settle_release();
    en = 1'b1;
  endtask

  task automatic test_ack_idle();
    ack_pulse();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: valid=%b, want 0", valid);
    end
    z = 4'b0001;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (valid !== 1'b1 || a !== 2'b00) begin
      errors++;
      $display("FAIL ack_idle_press: valid=%b a=%b, want valid=1 a=00", valid, a);
    end
    $display("ack_idle: stray ack ignored, next press a=%b", a);
    ack_pulse();
    settle_release();
  endtask

  task automatic test_reset_in_hold();
    z = 4'b1000;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (valid !== 1'b1 || a !== 2'b11) begin
      errors++;
      $display("FAIL rhold_press: valid=%b a=%b, want valid=1 a=11", valid, a);
    end
    rst = 1'b1;
    ack = 1'b1;
    step();
    rst = 1'b0;
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || a !== 2'b00 || multi !== 1'b0) begin
      errors++;
      $display("FAIL rhold_clear: valid=%b a=%b multi=%b, want valid=0 a=00 multi=0", valid, a, multi);
    end
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (valid !== 1'b1 || a !== 2'b11) begin
      errors++;
      $display("FAIL rhold_repress: valid=%b a=%b, want valid=1 a=11", valid, a);
    end
    $display("reset_in_hold: cleared then re-pressed, a=%b", a);
    ack_pulse();
    settle_release();
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    z   = 4'b0000;
    ack = 1'b0;
    test_reset();
    test_press();
    test_bounce();
    test_multi();
    test_change_during_debounce();
    test_enable();
    test_ack_idle();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_encoder_4_2.md
KEYPAD_ENCODER_4_2 -- requirements
Module: keypad_encoder_4_2

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DB_CYCLES SHALL default to 4 and SHALL be the number of consecutive stable cycles required for debounce; legal range is 2..65535.
REQ-003 Port clk SHALL be: input, 1 bit, rising-edge clock for all state.
REQ-004 Port rst SHALL be: input, 1 bit, synchronous active-high reset.
REQ-005 Port en SHALL be: input, 1 bit, enable; no new event is accepted while low.
REQ-006 Port z SHALL be: input, 4 bits, raw asynchronous active-high request lines (buttons or decoder outputs).
REQ-007 Port ack SHALL be: input, 1 bit, consumer accepts the current code.
REQ-008 Port a SHALL be: output, 2 bits, registered index of the highest-priority asserted line.
REQ-009 Port valid SHALL be: output, 1 bit, registered; high while a holds an unaccepted code.
REQ-010 Port multi SHALL be: output, 1 bit, registered; high when the captured pattern had more than one line set.

Function
REQ-011 z SHALL pass through a 2-flop synchronizer; zs denotes the synchronized value, and all logic SHALL use only zs.
REQ-012 Priority SHALL be z[3] > z[2] > z[1] > z[0], encoded as 11, 10, 01, 00.
REQ-013 The FSM SHALL have exactly four states: IDLE, DEBOUNCE, HOLD, RELEASE.
REQ-014 IDLE behaviour:
- If en=1 and zs is nonzero, the block SHALL capture p<=zs, clear the 16-bit counter and go to DEBOUNCE.
- Otherwise it SHALL stay in IDLE.
REQ-015 DEBOUNCE transitions:
- en=0: go to IDLE.
- zs=0: go to IDLE.
- zs nonzero and zs!=p: set p<=zs and clear the counter.
- zs==p: increment the counter.
REQ-016 DEBOUNCE exit: on the edge ending the DB_CYCLES-th consecutive cycle with zs==p, the block SHALL load a<=enc(p), set valid<=1 and go to HOLD.
REQ-017 Latency for a clean input: valid SHALL rise exactly DB_CYCLES+3 clock edges after the first edge that samples the new stable z.
REQ-018 HOLD:
- a, multi and valid SHALL remain constant.
- ack=1 SHALL clear valid on that edge and move the FSM to RELEASE.
- en=0 SHALL NOT cancel a pending valid.
REQ-019 An ack while valid=0 SHALL be ignored in every state.
REQ-020 RELEASE: the block SHALL return to IDLE after DB_CYCLES consecutive cycles with zs=0; any nonzero zs SHALL clear the count.
- Consequence: one press yields exactly one valid.
REQ-021 a SHALL retain its last value outside HOLD; only valid qualifies it.

Reset
REQ-022 While rst=1 on a clock edge, the block SHALL force:
- FSM to IDLE, counter to 0, p to 0, synchronizer flops to 0.
- a=00, valid=0, multi=0.
REQ-023 Reset SHALL take precedence over all inputs, including during HOLD with ack=1.
REQ-024 After reset deasserts, a held z SHALL be treated as a new press and SHALL obey REQ-017 latency.

Configuration
REQ-025 Macro MULTI_DETECT_EN SHALL control multi-line detection.
- Defined: multi SHALL load (popcount(p)>1) together with a at the DEBOUNCE exit.
- Undefined: multi SHALL be constant 0 and the popcount logic SHALL be absent.
- Port list SHALL be identical in both builds.

Verification
REQ-026 Reset with z=1111, rst=1 for 2 cycles -> a=00, valid=0, multi=0; after release, valid=1, a=11 after exactly 7 clocks (DB_CYCLES=4).
REQ-027 en=1, z=0100 held; after valid, ack for 1 cycle -> valid=1, a=10 at clock 7; valid=0 after the ack edge; no second valid while z is held 50 cycles.
REQ-028 z toggling 0100/0000 every 2 cycles for 20 cycles, then stable 0100 -> exactly one valid pulse-hold, a=10.
REQ-029 z=1011 -> a=11; multi=1 with MULTI_DETECT_EN defined, multi=0 without it.
REQ-030 en handling:
- en=0 with z=0010 for 20 cycles -> valid stays 0.
- en dropped at debounce cycle 2 -> valid stays 0.
- en dropped in HOLD -> valid stays 1 until ack.
REQ-031 rst pulsed for 1 cycle during HOLD -> valid=0 and a=00 on the next edge; no ack is required.
